// File: rtl/alu_result_sel_seq.sv
// alu_result_sel_seq: write-back result selector for the ALU.
// Picks SUM / SLTI directly, or runs a 1-bit-per-cycle shifter for SLL / SRA,
// then presents the registered result on a valid/ready output handshake.
module alu_result_sel_seq #(
    parameter int unsigned          WIDTH   = 16,
    parameter int unsigned          SEL_W   = 4,
    parameter int unsigned          SHAMT_W = $clog2(WIDTH),
    parameter logic [SEL_W-1:0]     OP_SLTI = 4'b0001,
    parameter logic [SEL_W-1:0]     OP_SLL  = 4'b0110,
    parameter logic [SEL_W-1:0]     OP_SRA  = 4'b0111
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   S,
    input  logic [WIDTH-1:0]   Hyrja0,
    input  logic [WIDTH-1:0]   Hyrja1,
    input  logic [WIDTH-1:0]   ShiftSrc,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Out,
    output logic               busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               sra_q, sra_d;

    logic               accept;
    logic               is_shift;
    logic [WIDTH-1:0]   shifted;

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = Reset_n & ((state_q == StIdle) | ((state_q == StHold) & out_ready));
        accept    = in_valid & in_ready;
        out_valid = (state_q == StHold);
        busy      = (state_q == StShift);
        Out       = out_q;
        is_shift  = (S == OP_SLL) | (S == OP_SRA);
        // One step of the iterative shifter; SRA replicates the sign bit
        shifted   = sra_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
    end

    // Next-state logic: accept/decode, shift iteration, result hand-off
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sra_d   = sra_q;

        unique case (state_q)
            StIdle, StHold: begin
                // Result consumed with nothing new behind it
                if ((state_q == StHold) && out_ready && !accept) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (is_shift) begin
                        work_d = ShiftSrc;
                        cnt_d  = Shamt;
                        sra_d  = (S == OP_SRA);
                        if (Shamt == '0) begin
                            out_d   = ShiftSrc;
                            state_d = StHold;
                        end else begin
                            state_d = StShift;
                        end
                    end else begin
                        out_d   = (S == OP_SLTI) ? Hyrja1 : Hyrja0;
                        state_d = StHold;
                    end
                end
            end
            StShift: begin
                work_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    out_d   = shifted;
                    state_d = StHold;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            sra_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            sra_q   <= sra_d;
        end
    end

endmodule
